// File: rtl/host_cmd_pkg.sv
// -----------------------------------------------------------------------------
// host_cmd_pkg
// Shared definitions for the host command master:
//   - frame header opcodes for each command kind
//   - CMD_TYPE encodings
//   - FSM state encoding
//   - per-command frame length and response length helpers
//   - frame builder used when a request is accepted
// -----------------------------------------------------------------------------
package host_cmd_pkg;

    localparam logic [7:0] OP_WR      = 8'hAA;
    localparam logic [7:0] OP_RD      = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WR      = 2'b00,
        CMD_RD      = 2'b01,
        CMD_ALU_OP  = 2'b10,
        CMD_ALU_NOP = 2'b11
    } cmd_type_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Byte 0 is the header and goes out first.
    typedef logic [3:0][7:0] frame_t;

    function automatic logic [2:0] frame_len(input logic [1:0] t);
        logic [2:0] n;
        case (t)
            CMD_WR:     n = 3'd3;
            CMD_RD:     n = 3'd2;
            CMD_ALU_OP: n = 3'd4;
            default:    n = 3'd2;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] rsp_len(input logic [1:0] t);
        logic [1:0] n;
        case (t)
            CMD_WR:  n = 2'd0;
            CMD_RD:  n = 2'd1;
            default: n = 2'd2;
        endcase
        return n;
    endfunction

    function automatic frame_t build_frame(input logic [1:0] t,
                                           input logic [3:0] addr,
                                           input logic [7:0] wdata,
                                           input logic [7:0] opa,
                                           input logic [7:0] opb,
                                           input logic [3:0] fun);
        frame_t f;
        f = '0;
        case (t)
            CMD_WR: begin
                f[0] = OP_WR;
                f[1] = {4'h0, addr};
                f[2] = wdata;
            end
            CMD_RD: begin
                f[0] = OP_RD;
                f[1] = {4'h0, addr};
            end
            CMD_ALU_OP: begin
                f[0] = OP_ALU_OP;
                f[1] = opa;
                f[2] = opb;
                f[3] = {4'h0, fun};
            end
            default: begin
                f[0] = OP_ALU_NOP;
                f[1] = {4'h0, fun};
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/host_cmd_master_if.sv
// -----------------------------------------------------------------------------
// host_cmd_master_if
// Bundles the command, UART TX/RX byte and response signals of the host
// command master.
//   master modport : view of the host_cmd_master itself
//   slave  modport : view of the agent driving commands / UART side
// Signals:
//   CMD_REQ/TYPE/ADDR/WDATA/OPA/OPB/FUN : command request and fields
//   CMD_BUSY                            : transaction in progress
//   TX_P_DATA/TX_D_VLD/TX_RDY           : frame byte stream with handshake
//   RX_P_DATA/RX_D_VLD                  : received response bytes
//   RSP_DATA/RSP_VLD/RSP_TIMEOUT        : completion result and pulses
// -----------------------------------------------------------------------------
interface host_cmd_master_if;
    import host_cmd_pkg::*;

    logic        CMD_REQ;
    logic [1:0]  CMD_TYPE;
    logic [3:0]  CMD_ADDR;
    logic [7:0]  CMD_WDATA;
    logic [7:0]  CMD_OPA;
    logic [7:0]  CMD_OPB;
    logic [3:0]  CMD_FUN;
    logic        CMD_BUSY;

    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_RDY;

    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;

    logic [15:0] RSP_DATA;
    logic        RSP_VLD;
    logic        RSP_TIMEOUT;

    modport master (
        input  CMD_REQ, CMD_TYPE, CMD_ADDR, CMD_WDATA, CMD_OPA, CMD_OPB, CMD_FUN,
        output CMD_BUSY,
        output TX_P_DATA, TX_D_VLD,
        input  TX_RDY,
        input  RX_P_DATA, RX_D_VLD,
        output RSP_DATA, RSP_VLD, RSP_TIMEOUT
    );

    modport slave (
        output CMD_REQ, CMD_TYPE, CMD_ADDR, CMD_WDATA, CMD_OPA, CMD_OPB, CMD_FUN,
        input  CMD_BUSY,
        input  TX_P_DATA, TX_D_VLD,
        output TX_RDY,
        output RX_P_DATA, RX_D_VLD,
        input  RSP_DATA, RSP_VLD, RSP_TIMEOUT
    );

endinterface

// File: rtl/rsp_timer.sv
// -----------------------------------------------------------------------------
// rsp_timer
// Response-wait counter. Counts enabled cycles since the last clear and flags
// the cycle on which TIMEOUT_CYC-1 is reached.
// Ports:
//   CLK, RST  : clock, asynchronous active-high reset
//   i_clear   : force the count to zero (takes priority over enable)
//   i_enable  : count this cycle
//   o_expire  : enable high and count at TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module rsp_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    import host_cmd_pkg::*;

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;
    logic          w_hit;

    assign w_hit    = (r_cnt == LAST);
    assign o_expire = i_enable & w_hit;

    // Hold at LAST so the count never wraps if the owner stays enabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_hit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/host_cmd_master.sv
// -----------------------------------------------------------------------------
// host_cmd_master
// Turns a host command into a UART byte frame, then collects the response
// bytes and reports the result (or a timeout).
// Ports:
//   CLK     : single clock, rising edge
//   RST     : asynchronous active-high reset
//   if_cmd  : host_cmd_master_if.master (command, TX, RX and response signals)
// Parameter:
//   TIMEOUT_CYC : response-wait limit in CLK cycles
// -----------------------------------------------------------------------------
module host_cmd_master
    import host_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    host_cmd_master_if.master if_cmd
);

    logic [1:0]  r_state;
    frame_t      r_frame;
    logic [2:0]  r_len;
    logic [1:0]  r_idx;
    logic [1:0]  r_type;
    logic        r_rx_cnt;
    logic [7:0]  r_lsb;
    logic [7:0]  r_tx_data;
    logic        r_tx_vld;
    logic        r_busy;
    logic [15:0] r_rsp_data;
    logic        r_rsp_vld;
    logic        r_rsp_to;

    frame_t      w_new_frame;
    logic        w_tx_acc;
    logic        w_last;
    logic        w_in_wait;
    logic        w_expire;

    assign w_new_frame = build_frame(if_cmd.CMD_TYPE, if_cmd.CMD_ADDR, if_cmd.CMD_WDATA,
                                     if_cmd.CMD_OPA, if_cmd.CMD_OPB, if_cmd.CMD_FUN);
    assign w_tx_acc    = r_tx_vld & if_cmd.TX_RDY;
    assign w_last      = w_tx_acc & ({1'b0, r_idx} == (r_len - 3'd1));
    assign w_in_wait   = (r_state == ST_WAIT);

    // Outside WAIT the counter is held at zero, so it always starts fresh on
    // entry; every received byte restarts it.
    rsp_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rsp_timer (
        .CLK      (CLK),
        .RST      (RST),
        .i_clear  (~w_in_wait | if_cmd.RX_D_VLD),
        .i_enable (w_in_wait),
        .o_expire (w_expire)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_frame    <= '0;
            r_len      <= 3'd0;
            r_idx      <= 2'd0;
            r_type     <= 2'd0;
            r_rx_cnt   <= 1'b0;
            r_lsb      <= 8'h00;
            r_tx_data  <= 8'h00;
            r_tx_vld   <= 1'b0;
            r_busy     <= 1'b0;
            r_rsp_data <= 16'h0000;
            r_rsp_vld  <= 1'b0;
            r_rsp_to   <= 1'b0;
        end else begin
            r_rsp_vld <= 1'b0;
            r_rsp_to  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (if_cmd.CMD_REQ) begin
                        r_frame   <= w_new_frame;
                        r_len     <= frame_len(if_cmd.CMD_TYPE);
                        r_type    <= if_cmd.CMD_TYPE;
                        r_idx     <= 2'd0;
                        r_tx_data <= w_new_frame[0];
                        r_tx_vld  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Next byte is loaded on the accepting edge, so TX_D_VLD
                    // stays high across the whole frame.
                    if (w_last) begin
                        r_tx_vld  <= 1'b0;
                        r_tx_data <= 8'h00;
                        r_rx_cnt  <= 1'b0;
                        if (r_type == CMD_WR) begin
                            r_rsp_data <= 16'h0000;
                            r_rsp_vld  <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (w_tx_acc) begin
                        r_idx     <= r_idx + 2'd1;
                        r_tx_data <= r_frame[r_idx + 2'd1];
                    end
                end
                ST_WAIT: begin
                    // A byte on the expiry cycle wins over the timeout.
                    if (if_cmd.RX_D_VLD) begin
                        if (rsp_len(r_type) == 2'd1) begin
                            r_rsp_data <= {8'h00, if_cmd.RX_P_DATA};
                            r_rsp_vld  <= 1'b1;
                            r_state    <= ST_DONE;
                        end else if (!r_rx_cnt) begin
                            r_lsb    <= if_cmd.RX_P_DATA;
                            r_rx_cnt <= 1'b1;
                        end else begin
                            r_rsp_data <= {if_cmd.RX_P_DATA, r_lsb};
                            r_rsp_vld  <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end else if (w_expire) begin
                        r_rsp_to <= 1'b1;
                        r_busy   <= 1'b0;
                        r_rx_cnt <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_cmd.CMD_BUSY    = r_busy;
    assign if_cmd.TX_P_DATA   = r_tx_data;
    assign if_cmd.TX_D_VLD    = r_tx_vld;
    assign if_cmd.RSP_DATA    = r_rsp_data;
    assign if_cmd.RSP_VLD     = r_rsp_vld;
    assign if_cmd.RSP_TIMEOUT = r_rsp_to;

endmodule

// File: tb/tb_host_cmd_master.sv
`timescale 1ns/1ps
module tb_host_cmd_master;
    import host_cmd_pkg::*;

    localparam int TO = 32;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    host_cmd_master_if u_if();

    host_cmd_master #(.TIMEOUT_CYC(TO)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .if_cmd (u_if.master)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] d;
        bit         first;
        bit         last_wr;
    } tx_exp_t;

    typedef struct {
        bit          to;
        logic [15:0] d;
    } rsp_exp_t;

    tx_exp_t     tx_q[$];
    rsp_exp_t    rsp_q[$];
    logic [15:0] rsp_model = 16'h0000;
    bit          bp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // TX_RDY: always ready, or low three cycles out of every four.
    initial begin
        int ph;
        ph = 0;
        u_if.TX_RDY = 1'b1;
        forever begin
            @(posedge CLK); #1;
            if (bp_en) begin
                u_if.TX_RDY = (ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                u_if.TX_RDY = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic       prev_vld, prev_rdy, pend_wr;
        logic [7:0] prev_data;
        tx_exp_t    e;
        rsp_exp_t   r;
        prev_vld = 0; prev_rdy = 0; pend_wr = 0; prev_data = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_vld = 0; prev_rdy = 0; pend_wr = 0;
                rsp_model = 16'h0000;
            end else begin
                if (pend_wr) begin
                    chk("wr_rsp_latency", {31'd0, u_if.RSP_VLD}, 32'd1);
                    pend_wr = 0;
                end
                if (prev_vld && !prev_rdy) begin
                    chk("tx_hold_vld", {31'd0, u_if.TX_D_VLD}, 32'd1);
                    chk("tx_hold_data", {24'd0, u_if.TX_P_DATA}, {24'd0, prev_data});
                end
                if (u_if.TX_D_VLD && u_if.TX_RDY) begin
                    if (tx_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL tx_unexpected actual=%0h required=none", u_if.TX_P_DATA);
                    end else begin
                        e = tx_q.pop_front();
                        chk("tx_byte", {24'd0, u_if.TX_P_DATA}, {24'd0, e.d});
                        if (!e.first) chk("tx_no_gap", {31'd0, prev_vld}, 32'd1);
                        if (e.last_wr) pend_wr = 1;
                    end
                end
                if (u_if.RSP_VLD || u_if.RSP_TIMEOUT) begin
                    chk("rsp_exclusive", {31'd0, u_if.RSP_VLD & u_if.RSP_TIMEOUT}, 32'd0);
                    if (rsp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rsp_unexpected actual=vld%0d/to%0d required=none",
                                 u_if.RSP_VLD, u_if.RSP_TIMEOUT);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("rsp_kind_timeout", {31'd0, u_if.RSP_TIMEOUT}, {31'd0, r.to});
                        if (!r.to) begin
                            chk("rsp_data", {16'd0, u_if.RSP_DATA}, {16'd0, r.d});
                            rsp_model = r.d;
                        end
                    end
                end
                if (!u_if.RSP_VLD)
                    chk("rsp_hold", {16'd0, u_if.RSP_DATA}, {16'd0, rsp_model});
                prev_vld  = u_if.TX_D_VLD;
                prev_rdy  = u_if.TX_RDY;
                prev_data = u_if.TX_P_DATA;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLK);
        while (u_if.CMD_BUSY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (u_if.CMD_BUSY) begin
            checks++; failures++;
            $display("FAIL wait_idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic wait_in_wait();
        int n;
        n = 0;
        @(negedge CLK);
        while (!(u_if.CMD_BUSY && !u_if.TX_D_VLD) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (!(u_if.CMD_BUSY && !u_if.TX_D_VLD)) begin
            checks++; failures++;
            $display("FAIL wait_rsp_state_timeout actual=busy%0d/vld%0d required=busy1/vld0",
                     u_if.CMD_BUSY, u_if.TX_D_VLD);
        end
    endtask

    task automatic exp_rsp(input bit to, input logic [15:0] d);
        rsp_exp_t r;
        r.to = to; r.d = d;
        rsp_q.push_back(r);
    endtask

    task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                         input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f,
                         input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] eb[4];
        tx_exp_t    e;
        eb[0] = b0; eb[1] = b1; eb[2] = b2; eb[3] = b3;
        wait_idle();
        for (int i = 0; i < n; i++) begin
            e.d = eb[i];
            e.first = (i == 0);
            e.last_wr = (t == 2'b00) && (i == n - 1);
            tx_q.push_back(e);
        end
        @(posedge CLK); #1;
        u_if.CMD_TYPE = t; u_if.CMD_ADDR = a; u_if.CMD_WDATA = wd;
        u_if.CMD_OPA = oa; u_if.CMD_OPB = ob; u_if.CMD_FUN = f;
        u_if.CMD_REQ = 1'b1;
        @(posedge CLK); #1;
        u_if.CMD_REQ = 1'b0;
        @(negedge CLK);
        chk("hdr_vld", {31'd0, u_if.TX_D_VLD}, 32'd1);
        chk("hdr_data", {24'd0, u_if.TX_P_DATA}, {24'd0, b0});
        chk("busy_set", {31'd0, u_if.CMD_BUSY}, 32'd1);
    endtask

    task automatic rx_byte(input logic [7:0] d);
        @(posedge CLK); #1;
        u_if.RX_D_VLD = 1'b1; u_if.RX_P_DATA = d;
        @(posedge CLK); #1;
        u_if.RX_D_VLD = 1'b0; u_if.RX_P_DATA = 8'h00;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        RST = 1'b1;
        u_if.CMD_REQ = 0; u_if.CMD_TYPE = 0; u_if.CMD_ADDR = 0; u_if.CMD_WDATA = 0;
        u_if.CMD_OPA = 0; u_if.CMD_OPB = 0; u_if.CMD_FUN = 0;
        u_if.RX_D_VLD = 0; u_if.RX_P_DATA = 0;
        repeat (3) @(negedge CLK);
        chk("rst_tx_vld", {31'd0, u_if.TX_D_VLD}, 32'd0);
        chk("rst_tx_data", {24'd0, u_if.TX_P_DATA}, 32'd0);
        chk("rst_busy", {31'd0, u_if.CMD_BUSY}, 32'd0);
        chk("rst_rsp_data", {16'd0, u_if.RSP_DATA}, 32'd0);
        chk("rst_rsp_vld", {31'd0, u_if.RSP_VLD}, 32'd0);
        chk("rst_rsp_to", {31'd0, u_if.RSP_TIMEOUT}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Register write, always ready
        issue(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 3, 8'hAA, 8'h05, 8'h3C, 8'h00);
        exp_rsp(0, 16'h0000);

        // Register read, response after ~10 cycles
        issue(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 2, 8'hBB, 8'h02, 8'h00, 8'h00);
        exp_rsp(0, 16'h007E);
        repeat (9) @(posedge CLK);
        rx_byte(8'h7E);

        // ALU with operands under backpressure; response bytes spaced so the
        // total wait exceeds the limit but each gap does not
        bp_en = 1'b1;
        issue(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1, 4, 8'hCC, 8'h12, 8'h34, 8'h01);
        exp_rsp(0, 16'h0046);
        wait_in_wait();
        bp_en = 1'b0;
        repeat (20) @(posedge CLK);
        rx_byte(8'h46);
        repeat (20) @(posedge CLK);
        rx_byte(8'h00);

        // Read whose byte lands on the expiry cycle: data wins
        issue(2'b01, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0, 2, 8'hBB, 8'h03, 8'h00, 8'h00);
        exp_rsp(0, 16'h009C);
        wait_in_wait();
        repeat (TO - 1) @(posedge CLK);
        #1;
        u_if.RX_D_VLD = 1'b1; u_if.RX_P_DATA = 8'h9C;
        @(posedge CLK); #1;
        u_if.RX_D_VLD = 1'b0; u_if.RX_P_DATA = 8'h00;

        // ALU without operands, no response: timeout
        issue(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 2, 8'hDD, 8'h02, 8'h00, 8'h00);
        exp_rsp(1, 16'h0000);
        wait_in_wait();
        k = 0;
        for (int i = 0; i < TO + 8; i++) begin
            @(negedge CLK);
            k++;
            if (u_if.RSP_TIMEOUT) break;
        end
        chk("timeout_latency", k, TO);
        chk("timeout_busy_low", {31'd0, u_if.CMD_BUSY}, 32'd0);
        chk("timeout_rsp_data", {16'd0, u_if.RSP_DATA}, 32'h009C);
        @(negedge CLK);
        chk("timeout_pulse_width", {31'd0, u_if.RSP_TIMEOUT}, 32'd0);

        // ALU without operands, normal two-byte response
        issue(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h5, 2, 8'hDD, 8'h05, 8'h00, 8'h00);
        exp_rsp(0, 16'h1234);
        wait_in_wait();
        rx_byte(8'h34);
        rx_byte(8'h12);

        // Noise during SEND: stray RX byte and CMD_REQ must not disturb anything
        bp_en = 1'b1;
        issue(2'b10, 4'h0, 8'h00, 8'hA1, 8'hB2, 4'h3, 4, 8'hCC, 8'hA1, 8'hB2, 8'h03);
        exp_rsp(0, 16'h2211);
        repeat (2) @(posedge CLK);
        #1;
        u_if.CMD_REQ = 1'b1; u_if.CMD_TYPE = 2'b00; u_if.CMD_ADDR = 4'hF; u_if.CMD_WDATA = 8'h99;
        u_if.RX_D_VLD = 1'b1; u_if.RX_P_DATA = 8'hFF;
        @(posedge CLK); #1;
        u_if.CMD_REQ = 1'b0; u_if.RX_D_VLD = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        u_if.RX_D_VLD = 1'b1; u_if.RX_P_DATA = 8'hEE;
        @(posedge CLK); #1;
        u_if.RX_D_VLD = 1'b0;
        wait_in_wait();
        bp_en = 1'b0;
        rx_byte(8'h11);
        rx_byte(8'h22);

        // Reset during the second TX byte of a write
        issue(2'b00, 4'hC, 8'h77, 8'h00, 8'h00, 4'h0, 3, 8'hAA, 8'h0C, 8'h77, 8'h00);
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        chk("midrst_tx_vld", {31'd0, u_if.TX_D_VLD}, 32'd0);
        chk("midrst_tx_data", {24'd0, u_if.TX_P_DATA}, 32'd0);
        chk("midrst_busy", {31'd0, u_if.CMD_BUSY}, 32'd0);
        chk("midrst_rsp_data", {16'd0, u_if.RSP_DATA}, 32'd0);
        chk("midrst_rsp_vld", {31'd0, u_if.RSP_VLD}, 32'd0);
        chk("midrst_rsp_to", {31'd0, u_if.RSP_TIMEOUT}, 32'd0);
        tx_q.delete();
        rsp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (5) @(posedge CLK);
        issue(2'b01, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 2, 8'hBB, 8'h09, 8'h00, 8'h00);
        exp_rsp(0, 16'h005A);
        wait_in_wait();
        rx_byte(8'h5A);

        // RX noise while idle
        wait_idle();
        rx_byte(8'hEE);
        rx_byte(8'hEF);

        wait_idle();
        repeat (5) @(negedge CLK);
        chk("tx_queue_drained", tx_q.size(), 32'd0);
        chk("rsp_queue_drained", rsp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/host_cmd_master.md
HOST_CMD_MASTER -- requirements
Module: host_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024, SHALL set the response-wait limit in CLK cycles.
REQ-002 CLK  input  1  SHALL be the single clock; all logic on rising edge.
REQ-003 RST  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 CMD_REQ  input  1  SHALL be the command request strobe, sampled only while CMD_BUSY=0.
REQ-005 CMD_TYPE  input  2  SHALL select the command: 00 reg write, 01 reg read, 10 ALU with operands, 11 ALU without operands.
REQ-006 CMD_ADDR  input  4  SHALL be the register-file address for read/write.
REQ-007 CMD_WDATA  input  8  SHALL be the register write data.
REQ-008 CMD_OPA, CMD_OPB  input  8 each  SHALL be the ALU operands A and B.
REQ-009 CMD_FUN  input  4  SHALL be the ALU function code.
REQ-010 CMD_BUSY  output  1  SHALL be high from request acceptance until completion or timeout.
REQ-011 TX_P_DATA  output  8  SHALL be the frame byte to the UART transmitter.
REQ-012 TX_D_VLD  output  1  SHALL qualify TX_P_DATA.
REQ-013 TX_RDY  input  1  SHALL accept a byte in any cycle where TX_D_VLD=1 and TX_RDY=1.
REQ-014 RX_P_DATA  input  8 and RX_D_VLD  input  1  SHALL carry received response bytes, one per RX_D_VLD cycle.
REQ-015 RSP_DATA  output  16  SHALL be the completed response value.
REQ-016 RSP_VLD  output  1  SHALL be a one-cycle completion pulse.
REQ-017 RSP_TIMEOUT  output  1  SHALL be a one-cycle timeout pulse.

Function
REQ-018 The block SHALL use states IDLE, SEND, WAIT_RSP and DONE.
REQ-019 IDLE -> SEND SHALL occur when CMD_REQ=1 in IDLE. All CMD_* fields SHALL be latched in the same cycle.
REQ-020 Frames SHALL be: write {AA, {0,ADDR}, WDATA}; read {BB, {0,ADDR}}; ALU-operand {CC, OPA, OPB, {0,FUN}}; ALU-no-operand {DD, {0,FUN}}.
REQ-021 The header byte SHALL appear on TX with TX_D_VLD=1 in the cycle after acceptance.
REQ-022 TX_P_DATA SHALL hold stable while TX_D_VLD=1 and TX_RDY=0.
REQ-023 The next byte SHALL be presented in the cycle after each acceptance, with no TX_D_VLD gap inside a frame.
REQ-024 On acceptance of the last byte, a write command SHALL go to DONE and all other commands SHALL go to WAIT_RSP.
REQ-025 WAIT_RSP SHALL expect 1 byte for a read and 2 bytes (LSB first, then MSB) for either ALU command.
REQ-026 The read result SHALL be {8'h00, byte}. The ALU result SHALL be {MSB, LSB}. The write result SHALL be 16'h0000.
REQ-027 DONE SHALL last one cycle, assert RSP_VLD with RSP_DATA valid, and return to IDLE with CMD_BUSY=0 in the following cycle.
REQ-028 RSP_DATA SHALL hold its value until the next RSP_VLD.
REQ-029 The timeout counter SHALL clear on entry to WAIT_RSP and on each received byte.
REQ-030 Reaching TIMEOUT_CYC-1 without a byte SHALL pulse RSP_TIMEOUT, discard partial data, leave RSP_DATA unchanged, and return to IDLE.
REQ-031 A byte arriving on the same cycle the timeout would expire SHALL be taken as data; no timeout SHALL be signalled on that cycle.
REQ-032 RX_D_VLD in IDLE, SEND or DONE SHALL be ignored.
REQ-033 CMD_REQ while CMD_BUSY=1 SHALL be ignored without side effect.
REQ-034 RSP_VLD and RSP_TIMEOUT SHALL never both be high.

Reset
REQ-035 While RST=1, the block SHALL be in state IDLE.
REQ-036 While RST=1, TX_P_DATA=0, TX_D_VLD=0, CMD_BUSY=0, RSP_DATA=0, RSP_VLD=0 and RSP_TIMEOUT=0.
REQ-037 RST asserted mid-frame or mid-wait SHALL abandon the transaction; after RST falls, nothing of the abandoned transaction SHALL be resent.

Structure
REQ-038 Package host_cmd_pkg SHALL hold: opcode constants AA/BB/CC/DD; CMD_TYPE encodings; state encoding; frame length and response length per type.
REQ-039 The timeout counter SHALL be sub-module rsp_timer (inputs clear and enable; output expire).

Verification
REQ-040 Write, TX_RDY=1: CMD_TYPE=00, ADDR=5, WDATA=3C -> TX bytes AA,05,3C on consecutive cycles; RSP_VLD with RSP_DATA=0000 one cycle after 3C is accepted.
REQ-041 Read: CMD_TYPE=01, ADDR=2; RX 7E after 10 cycles -> TX bytes BB,02; RSP_VLD with RSP_DATA=007E.
REQ-042 ALU with backpressure: CMD_TYPE=10, OPA=12, OPB=34, FUN=1; TX_RDY low 3 cycles per byte -> TX bytes CC,12,34,01 each held stable; RX 46,00 -> RSP_DATA=0046.
REQ-043 Timeout: CMD_TYPE=11, FUN=2, no RX -> RSP_TIMEOUT pulse TIMEOUT_CYC cycles after WAIT_RSP entry; CMD_BUSY then low; RSP_DATA unchanged.
REQ-044 Reset mid-frame: RST during the 2nd TX byte -> all outputs 0 immediately; new request after release -> clean frame starting with its header.
REQ-045 Noise: RX_D_VLD and CMD_REQ pulsed during SEND -> no effect on the frame or on the response.
